// File: rtl/fpu_issue_regfile.sv
// fpu_issue_regfile: FP register file, RAW/WAW scoreboard and adder issue port
// Optional feature macro FPU_WB_FWD_EN: the same-cycle writeback is forwarded into ready and operands.
// Ports: clk, nreset (async active-low); host_we/host_addr/host_wdata load registers,
//        host_rdata is a 1-cycle registered read, host_err pulses on a dropped host write;
//        instr_valid/instr_ready/instr_srcA/instr_srcB/instr_dest form the issue request;
//        opA/opB/dest_in/new_instr drive the adder; wb_result/wb_enable/wb_dest are its writeback;
//        busy is high while adds are outstanding.
module fpu_issue_regfile #(
   parameter int NUM_REGS    = 16,
   parameter int ADD_LATENCY = 4
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        host_we,
   input  logic [3:0]  host_addr,
   input  logic [31:0] host_wdata,
   output logic [31:0] host_rdata,
   output logic        host_err,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [3:0]  instr_srcA,
   input  logic [3:0]  instr_srcB,
   input  logic [3:0]  instr_dest,
   output logic [31:0] opA,
   output logic [31:0] opB,
   output logic [3:0]  dest_in,
   output logic        new_instr,
   input  logic [31:0] wb_result,
   input  logic        wb_enable,
   input  logic [3:0]  wb_dest,
   output logic        busy
);
   logic [31:0]         regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending, pend_eff, wb_mask, set_mask;
   logic [2:0]          out_cnt, cnt_nxt;
   logic [31:0]         rd_a, rd_b;
   logic                accept, wb_legit, host_drop;
   assign wb_mask  = {{(NUM_REGS-1){1'b0}}, wb_enable} << wb_dest;
   assign accept   = instr_valid && instr_ready;
   assign set_mask = {{(NUM_REGS-1){1'b0}}, accept} << instr_dest;
`ifdef FPU_WB_FWD_EN
   // a register being written back this cycle is no longer a hazard and its value is on wb_result
   assign pend_eff = pending & ~wb_mask;
   assign rd_a     = (wb_enable && wb_dest == instr_srcA) ? wb_result : regs[instr_srcA];
   assign rd_b     = (wb_enable && wb_dest == instr_srcB) ? wb_result : regs[instr_srcB];
`else
   assign pend_eff = pending;
   assign rd_a     = regs[instr_srcA];
   assign rd_b     = regs[instr_srcB];
`endif
   assign instr_ready = !host_we && !pend_eff[instr_srcA] && !pend_eff[instr_srcB] && !pend_eff[instr_dest];
   // a writeback to a non-pending register is a protocol error and must not decrement the count
   assign wb_legit  = wb_enable && pending[wb_dest];
   assign host_drop = host_we && (pending[host_addr] || (wb_enable && wb_dest == host_addr));
   always_comb
      cnt_nxt = (accept && !wb_legit && out_cnt != 3'(ADD_LATENCY)) ? out_cnt + 3'd1 :
                (wb_legit && !accept && out_cnt != 3'd0)            ? out_cnt - 3'd1 : out_cnt;
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         pending    <= '0;
         out_cnt    <= '0;
         busy       <= 1'b0;
         new_instr  <= 1'b0;
         host_err   <= 1'b0;
         host_rdata <= '0;
         opA        <= '0;
         opB        <= '0;
         dest_in    <= '0;
      end else begin
         // host_drop guarantees the two writes never target the same register
         if (wb_enable) regs[wb_dest] <= wb_result;
         if (host_we && !host_drop) regs[host_addr] <= host_wdata;
         pending    <= (pending & ~wb_mask) | set_mask;
         out_cnt    <= cnt_nxt;
         busy       <= cnt_nxt != 3'd0;
         new_instr  <= accept;
         host_err   <= host_drop;
         host_rdata <= regs[host_addr];
         if (accept) begin
            opA     <= rd_a;
            opB     <= rd_b;
            dest_in <= instr_dest;
         end
      end
   end
endmodule

// File: tb/tb_fpu_issue_regfile.sv
// tb_fpu_issue_regfile: directed bench with a behavioural register-file model and an adder stand-in
module tb_fpu_issue_regfile;
`ifdef FPU_WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int LAT = 4;
   logic        clk = 1'b0;
   logic        nreset;
   logic        host_we, host_err, instr_valid, instr_ready, new_instr, wb_enable, busy;
   logic [3:0]  host_addr, instr_srcA, instr_srcB, instr_dest, dest_in, wb_dest;
   logic [31:0] host_wdata, host_rdata, opA, opB, wb_result;
   logic        m_en, a_en = 1'b0;
   logic [3:0]  m_d, a_d = '0;
   logic [31:0] m_r, a_r = '0;
   logic [31:0] res_tab [16];
   int          n_chk = 0, n_fail = 0, cyc = 0, k;
   typedef struct { int due; logic [3:0] d; logic [31:0] r; } wb_t;
   wb_t aq [$];
   logic [31:0] m_reg [16];
   bit          m_pend [16];
   int          m_cnt;
   bit          acc, legit;
   logic [31:0] e_opa, e_opb, e_rdata;
   logic [3:0]  e_dest;
   logic        e_new, e_err, e_busy;

   assign wb_enable = m_en | a_en;
   assign wb_dest   = m_en ? m_d : a_d;
   assign wb_result = m_en ? m_r : a_r;

   fpu_issue_regfile #(.NUM_REGS(16), .ADD_LATENCY(LAT)) dut (
      .clk(clk), .nreset(nreset), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_err(host_err), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_srcA(instr_srcA), .instr_srcB(instr_srcB), .instr_dest(instr_dest), .opA(opA), .opB(opB),
      .dest_in(dest_in), .new_instr(new_instr), .wb_result(wb_result), .wb_enable(wb_enable),
      .wb_dest(wb_dest), .busy(busy));

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit blocked(input logic [3:0] r);
      return m_pend[r] && !(FWD && wb_enable && wb_dest == r);
   endfunction

   function automatic logic model_ready();
      return !host_we && !blocked(instr_srcA) && !blocked(instr_srcB) && !blocked(instr_dest);
   endfunction

   function automatic logic [31:0] operand(input logic [3:0] r);
      return (FWD && wb_enable && wb_dest == r) ? wb_result : m_reg[r];
   endfunction

   // behavioural model: state changes at each clock edge from the rules of the block
   initial forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_cnt = 0; e_opa = '0; e_opb = '0; e_rdata = '0; e_dest = '0;
         e_new = 1'b0; e_err = 1'b0; e_busy = 1'b0;
      end else begin
         acc     = instr_valid && model_ready();
         legit   = wb_enable && m_pend[wb_dest];
         e_err   = host_we && (m_pend[host_addr] || (wb_enable && wb_dest == host_addr));
         e_rdata = m_reg[host_addr];
         e_new   = acc;
         if (acc) begin
            e_opa  = operand(instr_srcA);
            e_opb  = operand(instr_srcB);
            e_dest = instr_dest;
         end
         m_cnt = m_cnt + int'(acc) - int'(legit);
         if (m_cnt > LAT) m_cnt = LAT;
         if (m_cnt < 0) m_cnt = 0;
         if (wb_enable) begin
            m_reg[wb_dest]  = wb_result;
            m_pend[wb_dest] = 1'b0;
         end
         if (host_we && !e_err) m_reg[host_addr] = host_wdata;
         if (acc) m_pend[instr_dest] = 1'b1;
         e_busy = m_cnt != 0;
      end
   end

   // compare process
   initial forever begin
      @(negedge clk);
      chk("opA", opA, e_opa);
      chk("opB", opB, e_opb);
      chk("dest_in", 32'(dest_in), 32'(e_dest));
      chk("new_instr", 32'(new_instr), 32'(e_new));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("host_rdata", host_rdata, e_rdata);
      chk("host_err", 32'(host_err), 32'(e_err));
      chk("instr_ready", 32'(instr_ready), 32'(model_ready()));
   end

   // adder stand-in: samples new_instr and writes back LAT cycles later
   initial forever begin
      @(negedge clk);
      if (new_instr === 1'b1) aq.push_back('{cyc + LAT, dest_in, res_tab[dest_in]});
   end

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      a_en = 1'b0;
      if (aq.size() != 0 && aq[0].due == cyc) begin
         a_en = 1'b1;
         a_d  = aq[0].d;
         a_r  = aq[0].r;
         void'(aq.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [31:0] d);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      tick();
      host_we = 1'b0;
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
      instr_srcA = a; instr_srcB = b; instr_dest = d; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int i = 0;
      while ((busy || aq.size() != 0) && i < 40) begin
         tick();
         i++;
      end
      chk(nm, 32'(i < 40), 32'd1);
   endtask

   initial begin
      nreset = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; instr_valid = 1'b0;
      instr_srcA = '0; instr_srcB = '0; instr_dest = '0; m_en = 1'b0; m_d = '0; m_r = '0;
      for (int i = 0; i < 16; i++) res_tab[i] = 32'hC0000000 | 32'(i);
      res_tab[3] = 32'h40400000;
      res_tab[4] = 32'h40800000;
      tick();
      tick();
      chk("rst_opA", opA, 32'h0);
      chk("rst_opB", opB, 32'h0);
      chk("rst_dest_in", 32'(dest_in), 32'h0);
      chk("rst_new_instr", 32'(new_instr), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rdata", host_rdata, 32'h0);
      chk("rst_ready", 32'(instr_ready), 32'h1);
      nreset = 1'b1;
      tick();
      host_write(4'd1, 32'h3F800000);
      chk("hw1_no_err", 32'(host_err), 32'h0);
      host_write(4'd2, 32'h40000000);
      issue(4'd1, 4'd2, 4'd3);
      chk("acc_opA", opA, 32'h3F800000);
      chk("acc_opB", opB, 32'h40000000);
      chk("acc_dest_in", 32'(dest_in), 32'd3);
      chk("acc_new_instr", 32'(new_instr), 32'h1);
      chk("acc_busy", 32'(busy), 32'h1);
      instr_srcA = 4'd3; instr_srcB = 4'd0; instr_dest = 4'd0;
      #1;
      chk("raw_blocked", 32'(instr_ready), 32'h0);
      tick();
      chk("new_instr_pulse", 32'(new_instr), 32'h0);
      wait_idle("wb3_timeout");
      host_addr = 4'd3;
      tick();
      chk("rd3", host_rdata, 32'h40400000);
      chk("wb3_busy", 32'(busy), 32'h0);
      res_tab[3] = 32'h40A00000;
      instr_srcA = 4'd1; instr_srcB = 4'd2; instr_dest = 4'd3; instr_valid = 1'b1;
      tick();
      instr_srcA = 4'd3; instr_srcB = 4'd1; instr_dest = 4'd4;
      k = 0;
      for (int j = 1; j <= 12 && k == 0; j++) begin
         @(negedge clk);
         if (instr_ready) k = j;
         tick();
      end
      instr_valid = 1'b0;
      chk("dep_spacing", 32'(k), FWD ? 32'd5 : 32'd6);
      chk("dep_opA", opA, 32'h40A00000);
      chk("dep_opB", opB, 32'h3F800000);
      chk("dep_dest_in", 32'(dest_in), 32'd4);
      wait_idle("dep_timeout");
      host_addr = 4'd4;
      tick();
      chk("rd4", host_rdata, 32'h40800000);
      issue(4'd1, 4'd2, 4'd7);
      host_write(4'd7, 32'hDEADBEEF);
      chk("err_pending", 32'(host_err), 32'h1);
      tick();
      chk("err_pulse_end", 32'(host_err), 32'h0);
      wait_idle("wb7_timeout");
      host_addr = 4'd7;
      tick();
      chk("rd7_keeps_wb", host_rdata, 32'hC0000007);
      m_en = 1'b1; m_d = 4'd8; m_r = 32'h41000000;
      host_we = 1'b1; host_addr = 4'd8; host_wdata = 32'h12345678;
      tick();
      m_en = 1'b0; host_we = 1'b0;
      chk("err_wb_collide", 32'(host_err), 32'h1);
      tick();
      chk("rd8_wb_wins", host_rdata, 32'h41000000);
      for (int i = 0; i < 4; i++) begin
         issue(4'd1, 4'd2, 4'(9 + i));
         chk("b2b_new_instr", 32'(new_instr), 32'h1);
      end
      chk("b2b_busy", 32'(busy), 32'h1);
      wait_idle("b2b_timeout");
      issue(4'd2, 4'd1, 4'd6);
      m_en = 1'b1; m_d = 4'd5; m_r = 32'h41100000;
      instr_srcA = 4'd1; instr_srcB = 4'd2; instr_dest = 4'd5; instr_valid = 1'b1;
      tick();
      m_en = 1'b0; instr_valid = 1'b0;
      chk("same_new_instr", 32'(new_instr), 32'h1);
      instr_srcA = 4'd5; instr_srcB = 4'd0; instr_dest = 4'd0;
      #1;
      chk("pend5_set", 32'(instr_ready), 32'h0);
      wait_idle("same_timeout");
      issue(4'd1, 4'd2, 4'd12);
      tick();
      #2;
      nreset = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_new_instr", 32'(new_instr), 32'h0);
      chk("arst_opA", opA, 32'h0);
      instr_srcA = 4'd12; instr_srcB = 4'd12; instr_dest = 4'd12;
      #1;
      chk("arst_ready", 32'(instr_ready), 32'h1);
      tick();
      nreset = 1'b1;
      wait_idle("post_rst_timeout");
      chk("post_rst_busy", 32'(busy), 32'h0);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
